// File: rtl/fifo_serializer_pkg.sv
// Shared types and sizing helpers for the FIFO-to-serial shifter.
// Imported by the top level and the bit timer.
package fifo_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPTURE,
        SHIFT
    } ser_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int ser_cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read port and serial output bundle seen by the serializer.
// The master side is the serializer; the slave side is the FIFO plus line driver.
interface fifo_serializer_if #(
    parameter int WIDTH = 8
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             rd_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output rd_en,
        output ser_out,
        output ser_valid,
        output ser_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  rd_en,
        input  ser_out,
        input  ser_valid,
        input  ser_last
    );

endinterface

// File: rtl/fifo_serializer_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while running and flags the
// terminal count, which is where the serializer advances to the next bit.
module bit_timer
    import fifo_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W    = ser_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // With CLKS_PER_BIT == 1 the counter sits at zero and every run cycle ticks.
    assign tick = run && (cnt == CNT_LAST);

    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside a plain posedge-clk block; rstn is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a FIFO read port and shifts them out MSB first, each bit
// held for CLKS_PER_BIT clocks, with valid/last framing strobes.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    output logic               busy,
    fifo_serializer_if.master  sif
);

    localparam int               BIT_W      = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(WIDTH - 2);

    ser_state_t       state;
    logic [BIT_W-1:0] bit_cnt;
    // The current bit lives in ser_out_q, so only the remaining bits are held here.
    logic [WIDTH-2:0] shreg;
    logic             rd_en_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             ser_last_q;
    logic             tick;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state == CAPTURE),
        .run  (state == SHIFT),
        .tick (tick)
    );

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every branch sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rd_en_q     <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !sif.fifo_empty) begin
                        state   <= POP;
                        rd_en_q <= 1'b1;
                    end
                end
                POP: begin
                    state   <= CAPTURE;
                    rd_en_q <= 1'b0;
                end
                CAPTURE: begin
                    shreg       <= sif.fifo_data[WIDTH-2:0];
                    ser_out_q   <= sif.fifo_data[WIDTH-1];
                    ser_valid_q <= 1'b1;
                    ser_last_q  <= 1'b0;
                    bit_cnt     <= '0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            state       <= IDLE;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            ser_last_q  <= 1'b0;
                        end else begin
                            ser_out_q  <= shreg[WIDTH-2];
                            shreg      <= shreg << 1;
                            bit_cnt    <= bit_cnt + 1'b1;
                            ser_last_q <= (bit_cnt == BIT_PENULT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sif.rd_en     = rd_en_q;
    assign sif.ser_out   = ser_out_q;
    assign sif.ser_valid = ser_valid_q;
    assign sif.ser_last  = ser_last_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench: two serializers (CLKS_PER_BIT = 1 and 4), each fed by a
// small behavioural FIFO with a registered data_out.
module tb_fifo_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn1, en1, busy1;
    logic rstn4, en4, busy4;

    fifo_serializer_if #(.WIDTH(8)) sif1 ();
    fifo_serializer_if #(.WIDTH(8)) sif4 ();

    fifo_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .clk  (clk),
        .rstn (rstn1),
        .en   (en1),
        .busy (busy1),
        .sif  (sif1.master)
    );

    fifo_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) u4 (
        .clk  (clk),
        .rstn (rstn4),
        .en   (en4),
        .busy (busy4),
        .sif  (sif4.master)
    );

    // FIFO models: data_out updates on the edge that samples rd_en.
    logic [7:0] mem1 [16];
    logic [7:0] mem4 [16];
    logic [3:0] wp1 = '0, rp1 = '0, wp4 = '0, rp4 = '0;
    logic [7:0] dout1 = '0, dout4 = '0;

    assign sif1.fifo_empty = (wp1 == rp1);
    assign sif1.fifo_data  = dout1;
    assign sif4.fifo_empty = (wp4 == rp4);
    assign sif4.fifo_data  = dout4;

    always @(posedge clk) begin
        if (sif1.rd_en && (wp1 != rp1)) begin
            dout1 <= mem1[rp1];
            rp1   <= rp1 + 4'd1;
        end
        if (sif4.rd_en && (wp4 != rp4)) begin
            dout4 <= mem4[rp4];
            rp4   <= rp4 + 4'd1;
        end
    end

    task automatic push1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 4'd1;
    endtask

    task automatic push4(input logic [7:0] d);
        mem4[wp4] = d;
        wp4 = wp4 + 4'd1;
    endtask

    // {rd_en, ser_out, ser_valid, ser_last, busy}
    logic [4:0] o1, o4;
    assign o1 = {sif1.rd_en, sif1.ser_out, sif1.ser_valid, sif1.ser_last, busy1};
    assign o4 = {sif4.rd_en, sif4.ser_out, sif4.ser_valid, sif4.ser_last, busy4};

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic       en;
        logic [4:0] exp;
    } vec_t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl [11];
        int         rd_at [$];
        logic [7:0] words [3];
        int         nbits, last_bad, rdc, vcnt, lcnt, g1, g2, f1;
        logic [31:0] stream;
        logic       busy_end, s3, s7, v24, rd1, v2;

        // Single word 8'hA5 at one clock per bit, cycles 1..11 after release.
        tbl[0]  = '{1'b1, 5'b10001};
        tbl[1]  = '{1'b1, 5'b00001};
        tbl[2]  = '{1'b1, 5'b01101};
        tbl[3]  = '{1'b1, 5'b00101};
        tbl[4]  = '{1'b1, 5'b01101};
        tbl[5]  = '{1'b1, 5'b00101};
        tbl[6]  = '{1'b1, 5'b00101};
        tbl[7]  = '{1'b1, 5'b01101};
        tbl[8]  = '{1'b1, 5'b00101};
        tbl[9]  = '{1'b1, 5'b01111};
        tbl[10] = '{1'b1, 5'b00000};

        rstn1 = 1'b0; en1 = 1'b1;
        rstn4 = 1'b0; en4 = 1'b0;
        push1(8'hA5);

        // Reset held with a non-empty FIFO: nothing moves.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_c%0d", i), {27'd0, o1}, 32'd0);
        end
        rstn1 = 1'b1;

        for (int k = 0; k < 11; k++) begin
            en1 = tbl[k].en;
            @(negedge clk);
            check($sformatf("a5_cycle%0d", k + 1), {27'd0, o1}, {27'd0, tbl[k].exp});
        end

        // Back-to-back words: 3C, C3, FF.
        push1(8'h3C); push1(8'hC3); push1(8'hFF);
        words[0] = '0; words[1] = '0; words[2] = '0;
        nbits = 0; last_bad = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (sif1.rd_en) rd_at.push_back(k);
            if (sif1.ser_valid) begin
                if (nbits < 24) words[nbits / 8] = {words[nbits / 8][6:0], sif1.ser_out};
                if (sif1.ser_last != ((nbits % 8) == 7)) last_bad++;
                nbits++;
            end else if (sif1.ser_last) begin
                last_bad++;
            end
        end
        f1 = (rd_at.size() >= 1) ? rd_at[0] : -1;
        g1 = (rd_at.size() >= 2) ? rd_at[1] - rd_at[0] : -1;
        g2 = (rd_at.size() >= 3) ? rd_at[2] - rd_at[1] : -1;
        check("b2b_rd_en_pulses", rd_at.size(), 3);
        check("b2b_first_rd_en", f1, 1);
        check("b2b_gap1", g1, 11);
        check("b2b_gap2", g2, 11);
        check("b2b_word0", {24'd0, words[0]}, 32'h3C);
        check("b2b_word1", {24'd0, words[1]}, 32'hC3);
        check("b2b_word2", {24'd0, words[2]}, 32'hFF);
        check("b2b_valid_bits", nbits, 24);
        check("b2b_last_alignment", last_bad, 0);
        check("b2b_fifo_empty_end", {31'd0, sif1.fifo_empty}, 32'd1);
        check("b2b_busy_end", {31'd0, busy1}, 32'd0);

        // Bit stretching and en gating on the four-clock instance.
        rstn4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("cpb4_idle_after_reset", {27'd0, o4}, 32'd0);
        push4(8'h81); push4(8'h55);
        en4 = 1'b1;
        rdc = 0; vcnt = 0; lcnt = 0; stream = '0; busy_end = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (sif4.rd_en) rdc++;
            if (sif4.ser_valid) vcnt++;
            if (sif4.ser_last) lcnt++;
            if (k >= 3 && k <= 34) stream = {stream[30:0], sif4.ser_out};
            if (k == 35) busy_end = busy4;
            if (k == 15) en4 = 1'b0;
        end
        check("stretch_stream_81", stream, 32'hF000000F);
        check("stretch_valid_cycles", vcnt, 32);
        check("stretch_last_cycles", lcnt, 4);
        check("stretch_busy_after_word", {31'd0, busy_end}, 32'd0);
        check("engate_single_rd_en", rdc, 1);
        check("engate_fifo_still_full", {31'd0, sif4.fifo_empty}, 32'd0);

        en4 = 1'b1;
        @(negedge clk);
        check("en_reassert_rd_en", {31'd0, sif4.rd_en}, 32'd1);

        // Reset during bit 5 of 8'h55, then a fresh word 8'h96.
        s3 = 1'b1; s7 = 1'b0; v24 = 1'b0;
        for (int k = 2; k <= 24; k++) begin
            @(negedge clk);
            if (k == 3) s3 = sif4.ser_out;
            if (k == 7) s7 = sif4.ser_out;
            if (k == 24) v24 = sif4.ser_valid;
        end
        check("w55_bit0", {31'd0, s3}, 32'd0);
        check("w55_bit1", {31'd0, s7}, 32'd1);
        check("w55_valid_bit5", {31'd0, v24}, 32'd1);
        rstn4 = 1'b0;
        @(negedge clk);
        check("midword_reset_outputs", {27'd0, o4}, 32'd0);
        push4(8'h96);
        @(negedge clk);
        rstn4 = 1'b1;
        rdc = 0; stream = '0; rd1 = 1'b0; v2 = 1'b1; busy_end = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (sif4.rd_en) rdc++;
            if (k == 1) rd1 = sif4.rd_en;
            if (k == 2) v2 = sif4.ser_valid;
            if (k >= 3 && k <= 34) stream = {stream[30:0], sif4.ser_out};
            if (k == 36) busy_end = busy4;
        end
        check("post_reset_rd_en_c1", {31'd0, rd1}, 32'd1);
        check("post_reset_no_valid_c2", {31'd0, v2}, 32'd0);
        check("post_reset_stream_96", stream, 32'hF00F0FF0);
        check("post_reset_single_pop", rdc, 1);
        check("post_reset_idle_end", {31'd0, busy_end}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream consumer of the team's `fifo` block. It pops one word at a time from the FIFO read port and shifts it out serially, MSB first, holding each bit for a programmable number of clocks. Framing strobes (`ser_valid`, `ser_last`) let a line driver or a downstream deserializer recover word boundaries. It sits between the FIFO's `data_out`/`empty`/`rd_en` and the serial output pin logic.

## Interface
- `WIDTH`, 8, word width; must match the FIFO `WIDTH`; ≥2.
- `CLKS_PER_BIT`, 4, clocks each bit is held on `ser_out`; ≥1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `en`  in  1  permits starting a new word; a word already in progress always completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid the cycle after `rd_en` is sampled high.
- `rd_en`  out  1  FIFO read enable; registered; single-cycle pulse per word.
- `ser_out`  out  1  serial data; 0 when not shifting.
- `ser_valid`  out  1  high on every cycle a data bit is driven.
- `ser_last`  out  1  high during the final (LSB) bit period.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, POP, CAPTURE, SHIFT.
- IDLE: if `en && !fifo_empty` at an edge, go to POP and set `rd_en` to 1 at that edge. Otherwise stay.
- POP: `rd_en` = 1 for exactly this cycle. The FIFO samples it, and at the next edge the FIFO updates `data_out`. Go to CAPTURE and clear `rd_en`.
- CAPTURE: `fifo_data` is valid. At the edge, load it into the shift register, clear the bit counter and divider, and go to SHIFT.
- SHIFT:
  - `ser_out` = shift register MSB; `ser_valid` = 1.
  - The divider counts 0..`CLKS_PER_BIT`-1. On terminal count, shift left by one and increment the bit counter.
  - `ser_last` = 1 while the bit counter = `WIDTH`-1.
  - On terminal count of bit `WIDTH`-1, go to IDLE.
- `fifo_empty` is ignored outside IDLE. It may legitimately be stale for one cycle after a pop.
- `en` is sampled only in IDLE. Deasserting it mid-word has no effect until the word completes.
- Counter widths:
  - Bit counter is `$clog2(WIDTH)` bits and never exceeds `WIDTH`-1.
  - Divider is `max(1,$clog2(CLKS_PER_BIT))` bits and wraps at `CLKS_PER_BIT`-1.
  - When `CLKS_PER_BIT`=1, every SHIFT cycle is a terminal count.
- Reset mid-operation: state returns to IDLE, all outputs clear, and the word in flight is lost. The FIFO has already popped it; this is accepted behaviour.
- Outputs are registered, or decoded directly from registered state (`busy`), with no combinational path from inputs.

## Timing
- Reset value of every output is 0: `rd_en`, `ser_out`, `ser_valid`, `ser_last`, `busy`.
- Cycle count, with cycle 0 being the one in which IDLE samples `en && !fifo_empty`:
  - `rd_en` is high in cycle 1.
  - Capture happens in cycle 2.
  - The first data bit appears in cycle 3.
- A word occupies `WIDTH*CLKS_PER_BIT` SHIFT cycles.
- Word-to-word period with a non-empty FIFO is `3 + WIDTH*CLKS_PER_BIT` cycles: IDLE, POP and CAPTURE are one cycle each. `ser_valid` has a 3-cycle gap between words.
- `rd_en` never asserts on two consecutive cycles, so the FIFO can never be over-read.
- `ser_last` falls in the same cycle that `ser_valid` falls.

## Structure
- `fifo_serializer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, POP, CAPTURE, SHIFT} ser_state_t`;
  - a `ser_cnt_w` function returning `max(1,$clog2(n))`.
- One sub-module, `bit_timer`, is natural.
  - Parameter: `CLKS_PER_BIT`.
  - Inputs: `clk`, `rstn`, `clr`, `run`.
  - Output: `tick`, asserted on the divider's terminal count.
- The top level holds the FSM, the shift register and the bit counter.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with `fifo_empty`=0. Required: all outputs 0, no `rd_en`. Release: `rd_en` is high exactly 1 cycle later.
- Single word, `CLKS_PER_BIT`=1: FIFO model holds 8'hA5. Required: `ser_out` = 1,0,1,0,0,1,0,1 in cycles 3–10; `ser_valid` is high for 8 cycles; `ser_last` is high only in cycle 10; `busy` is low in cycle 11.
- Bit stretching, `CLKS_PER_BIT`=4, word 8'h81: `ser_out` is high for 4 cycles, low for 24, then high for 4. Total `ser_valid` = 32 cycles.
- Back-to-back, using a real `fifo` instance loaded with 8'h3C, 8'hC3, 8'hFF (`CLKS_PER_BIT`=1):
  - Required: exactly 3 `rd_en` pulses, 11 cycles apart.
  - Serial stream matches all three words.
  - FIFO `empty` is 1 at the end and no further `rd_en` occurs.
- `en` gating: drop `en` during bit 3 of a word. Required: the word completes and no new `rd_en` follows. Reasserting `en` produces `rd_en` 1 cycle later.
- Reset mid-word: assert `rstn`=0 during bit 5. Required: all outputs 0 at the next edge. After release with the FIFO non-empty, the next word starts cleanly from its MSB.
